// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, pulls a 1- or 2-byte instruction from
// byte-wide program memory and hands the assembled word to the decoder.
module fetch_unit #(
    parameter int unsigned LONG_BIT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_value,
    output logic        pc_read,
    output logic        pc_increment,
    output logic        pc_dual_op,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] instr,
    output logic        instr_len,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flush
);

    typedef enum logic [2:0] {
        LOAD,
        REQ0,
        REQ1,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [15:0] fetch_addr;
    logic [15:0] second_addr;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic        drain_second;
    logic        is_long;

    assign second_addr = fetch_addr + 16'd1;
    assign is_long     = byte0[LONG_BIT];

    // A flush never abandons a request already on the bus: without an ack it
    // parks in DRAIN until the memory answers, then discards the byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            fetch_addr   <= 16'h0000;
            byte0        <= 8'h00;
            byte1        <= 8'h00;
            drain_second <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (!flush) begin
                        fetch_addr <= pc_value;
                        state      <= REQ0;
                    end
                end
                REQ0: begin
                    if (flush) begin
                        drain_second <= 1'b0;
                        state        <= mem_ack ? LOAD : DRAIN;
                    end else if (mem_ack) begin
                        byte0 <= mem_rdata;
                        state <= mem_rdata[LONG_BIT] ? REQ1 : HOLD;
                    end
                end
                REQ1: begin
                    if (flush) begin
                        drain_second <= 1'b1;
                        state        <= mem_ack ? LOAD : DRAIN;
                    end else if (mem_ack) begin
                        byte1 <= mem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        state <= LOAD;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Address stays on whichever byte was outstanding, including while draining.
    always_comb begin
        mem_addr = 16'h0000;
        case (state)
            REQ0:    mem_addr = fetch_addr;
            REQ1:    mem_addr = second_addr;
            DRAIN:   mem_addr = drain_second ? second_addr : fetch_addr;
            default: mem_addr = 16'h0000;
        endcase
    end

    assign pc_read      = (state == LOAD);
    assign mem_req      = (state == REQ0) || (state == REQ1) || (state == DRAIN);
    assign instr_valid  = (state == HOLD);
    assign instr_len    = instr_valid && is_long;
    assign instr        = !instr_valid ? 16'h0000 :
                          is_long      ? {byte0, byte1} : {8'h00, byte0};
    assign pc_increment = instr_valid && instr_ready && !flush;
    assign pc_dual_op   = pc_increment && is_long;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter and upstream of the decoder. Reads the current PC, fetches a 1- or 2-byte instruction from byte-wide program memory over a req/ack handshake, and presents the assembled word to the decoder with a valid/ready handshake. On handoff it drives the PC's `increment`/`dual_op` inputs so the PC advances by the instruction length. A `flush` input discards in-flight work when the decoder redirects the PC.

## Interface

Parameters:
- `LONG_BIT`, default 7: opcode bit that marks a 2-byte instruction (1 = long).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_value`  in  16  PC output bus.
- `pc_read`  out  1  drives PC `read`.
- `pc_increment`  out  1  drives PC `increment`.
- `pc_dual_op`  out  1  drives PC `dual_op`.
- `mem_addr`  out  16  program memory byte address.
- `mem_req`  out  1  memory read request.
- `mem_ack`  in  1  memory read acknowledge, single-cycle pulse, data valid same cycle.
- `mem_rdata`  in  8  memory read data.
- `instr`  out  16  instruction word to decoder.
- `instr_len`  out  1  0 = 1 byte, 1 = 2 bytes.
- `instr_valid`  out  1  `instr`/`instr_len` valid.
- `instr_ready`  in  1  decoder accepts.
- `flush`  in  1  discard current fetch; PC is being set this cycle.

## Operation

- States: LOAD, REQ0, REQ1, HOLD, DRAIN.
- LOAD: `pc_read`=1; capture `pc_value` into `fetch_addr`; next REQ0 (or LOAD again if `flush`).
- REQ0: `mem_req`=1, `mem_addr`=`fetch_addr`. On `mem_ack`: store byte0; if `mem_rdata[LONG_BIT]`=1 go REQ1, else go HOLD.
- REQ1: `mem_req`=1, `mem_addr`=`fetch_addr`+1 (16-bit wrap, 16'hFFFF -> 16'h0000). On `mem_ack`: store byte1, go HOLD.
- HOLD: `instr_valid`=1. Short: `instr`={8'h00, byte0}, `instr_len`=0. Long: `instr`={byte0, byte1}, `instr_len`=1. `instr`/`instr_len` stable while valid && !ready.
- Handoff (HOLD, `instr_ready`=1, `flush`=0): `pc_increment`=1 and `pc_dual_op`=`instr_len`, combinational, that cycle only; next LOAD.
- `pc_increment`/`pc_dual_op` are 0 in all other cycles. PC `decrement`, `set` and `reset_on_clk` are not driven by this block.
- `mem_req` and `mem_addr` are held stable from assertion until the cycle `mem_ack` is sampled high; `mem_req` is 0 in the cycle after the ack unless a new request starts.
- Flush (priority over handoff and ack):
  - LOAD: stay in LOAD.
  - REQ0/REQ1 with `mem_ack`=1: discard data, go LOAD.
  - REQ0/REQ1 with `mem_ack`=0: go DRAIN. The request is never abandoned.
  - DRAIN: `mem_req`=1, same address; on `mem_ack` discard data, go LOAD. Further `flush` is ignored.
  - HOLD: no increment even if `instr_ready`=1; `instr_valid` is 0 next cycle; go LOAD.
- Reset (any state, asynchronous): state LOAD. All outputs 0 except `pc_read`=1, which is combinational from the LOAD state. `fetch_addr`, byte0 and byte1 are cleared to 0. An in-flight memory request is dropped; memory must tolerate this.

## Timing

- Zero-wait memory (ack in the first REQ cycle):
  - Short instruction: LOAD, REQ0, HOLD. `instr_valid` asserts 2 cycles after LOAD.
  - Long instruction: LOAD, REQ0, REQ1, HOLD (3 cycles).
- With ready held high, throughput is one short instruction per 3 cycles, or one long per 4.
- Each memory wait cycle adds one cycle of latency.
- PC updates on the edge ending the handoff cycle; the following LOAD samples the new value.
- On flush, the PC `set` occurs on the same edge that moves this block to LOAD/DRAIN, so LOAD always captures the redirected PC.

## Test plan

- Reset: hold `reset`=0 mid-REQ1. Then: state LOAD, `mem_req`=0, `instr_valid`=0, `pc_increment`=0, `instr`=0, `pc_read`=1.
- Short fetch: `pc_value`=16'h0010, zero-wait memory returns 8'h3A. Then: `mem_addr`=16'h0010; `instr`=16'h003A, `instr_len`=0 two cycles after LOAD; with ready=1, `pc_increment`=1, `pc_dual_op`=0 for one cycle.
- Long fetch with waits: PC=16'h0020, bytes 8'h85/8'h11, ack after 2 wait cycles each. Then: addresses 16'h0020 then 16'h0021; `instr`=16'h8511, `instr_len`=1; handoff gives `pc_increment`=1, `pc_dual_op`=1.
- Backpressure: `instr_ready`=0 for 5 cycles in HOLD. Then: `instr`, `instr_len` and `instr_valid` stable; no `pc_increment` until ready=1.
- Flush during pending REQ0 (no ack): enters DRAIN with `mem_req`/`mem_addr` unchanged until ack; data is discarded; next LOAD fetches the new PC 16'h0100; no `instr_valid` for the flushed fetch.
- Wrap: PC=16'hFFFF, long opcode. Then: REQ1 `mem_addr`=16'h0000; instruction assembled correctly.
